adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_if.sv | 31 +++
 rtl/adder_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - requester-side and adder-side signals of the round-robin adder arbiter
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W:0]         rsp_sum;
  logic               rsp_ovf;
  logic               rsp_err;
  logic               busy;
  logic               add_start;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic [W:0]         add_sum;
  logic               add_done;
  logic               add_overflow;

  modport slave (
    input  req, a_in, b_in, add_sum, add_done, add_overflow,
    output gnt, rsp_valid, rsp_sum, rsp_ovf, rsp_err, busy, add_start, add_a, add_b
  );

  modport master (
    output req, a_in, b_in, add_sum, add_done, add_overflow,
    input  gnt, rsp_valid, rsp_sum, rsp_ovf, rsp_err, busy, add_start, add_a, add_b
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one sequential adder among N_REQ requesters
module adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  adder_arbiter_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [TW-1:0]    timer;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [W:0]       rsp_sum_q;
  logic             rsp_ovf_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             add_start_q;
  logic [W-1:0]     add_a_q;
  logic [W-1:0]     add_b_q;

  logic             pick_valid;
  logic [IDW-1:0]   pick;

  // Scan downward so the requester closest above ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % N_REQ]) begin
        pick_valid = 1'b1;
        pick       = IDW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id          <= '0;
      timer       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      add_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state       <= S_ISSUE;
            id          <= pick;
            gnt_q       <= N_REQ'(1) << pick;
            add_start_q <= 1'b1;
            add_a_q     <= bus.a_in[int'(pick)*W +: W];
            add_b_q     <= bus.b_in[int'(pick)*W +: W];
            busy_q      <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (bus.add_done) begin
            state       <= S_RESP;
            rsp_valid_q <= N_REQ'(1) << id;
            rsp_sum_q   <= bus.add_sum;
            rsp_ovf_q   <= bus.add_overflow;
            rsp_err_q   <= 1'b0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= S_RESP;
            rsp_valid_q <= N_REQ'(1) << id;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          add_a_q <= '0;
          add_b_q <= '0;
          ptr     <= (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
endmodule
